// File: rtl/li_relay_station.sv
// Latency-insensitive relay station: one register stage on the valid/stop channel, with main/aux registers for full throughput.
// Optional stall-cycle counter enabled by defining LI_RS_STALL_COUNT_EN.
module li_relay_station #(
  parameter int WIDTH = 6
`ifdef LI_RS_STALL_COUNT_EN
  ,
  parameter int CNT_WIDTH = 16
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     i_data,
  input  logic                 i_valid,
  output logic                 o_stop,
  output logic [WIDTH-1:0]     o_data,
  output logic                 o_valid,
  input  logic                 i_stop
`ifdef LI_RS_STALL_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0] o_stall_cycles
`endif
);

  typedef enum logic {PROC, STALL} state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] main_data, aux_data;
  logic             main_valid, aux_valid;
  logic             main_load_in, main_load_aux, aux_load;

  always_ff @(posedge clk) begin
    if (reset) state <= PROC;
    else       state <= next_state;
  end

  // A void token in main never blocks the input, even when downstream stops.
  always_comb begin
    next_state    = state;
    main_load_in  = 1'b0;
    main_load_aux = 1'b0;
    aux_load      = 1'b0;
    unique case (state)
      PROC: begin
        if (!i_stop || !main_valid) begin
          main_load_in = 1'b1;
        end else if (i_valid) begin
          aux_load   = 1'b1;
          next_state = STALL;
        end
      end
      STALL: begin
        if (!i_stop) begin
          main_load_aux = 1'b1;
          next_state    = PROC;
        end
      end
      default: next_state = PROC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      main_data  <= '0;
      main_valid <= 1'b0;
      aux_data   <= '0;
      aux_valid  <= 1'b0;
    end else begin
      if (main_load_in) begin
        main_data  <= i_data;
        main_valid <= i_valid;
      end else if (main_load_aux) begin
        main_data  <= aux_data;
        main_valid <= aux_valid;
      end
      if (aux_load) begin
        aux_data  <= i_data;
        aux_valid <= 1'b1;
      end else if (main_load_aux) begin
        aux_valid <= 1'b0;
      end
    end
  end

  assign o_data  = main_data;
  assign o_valid = main_valid;
  assign o_stop  = (state == STALL);

`ifdef LI_RS_STALL_COUNT_EN
  logic [CNT_WIDTH-1:0] stall_cnt;

  // Saturates so long stalls read as "at least all-ones" rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if (state == STALL && stall_cnt != {CNT_WIDTH{1'b1}})
      stall_cnt <= stall_cnt + 1'b1;
  end

  assign o_stall_cycles = stall_cnt;
`endif

endmodule

// File: tb/tb_li_relay_station.sv
// Self-checking bench for li_relay_station: directed vectors plus a queue-referenced random stop/valid run.
// Define LI_RS_STALL_COUNT_EN to also exercise the saturating stall counter (CNT_WIDTH=4).
module tb_li_relay_station;

  localparam int WIDTH = 6;
`ifdef LI_RS_STALL_COUNT_EN
  localparam int CNT_WIDTH = 4;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] i_data;
  logic             i_valid;
  logic             o_stop;
  logic [WIDTH-1:0] o_data;
  logic             o_valid;
  logic             i_stop;
`ifdef LI_RS_STALL_COUNT_EN
  logic [CNT_WIDTH-1:0] o_stall_cycles;
`endif

  int checks = 0;
  int failures = 0;

  li_relay_station #(
    .WIDTH(WIDTH)
`ifdef LI_RS_STALL_COUNT_EN
    ,
    .CNT_WIDTH(CNT_WIDTH)
`endif
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .i_data (i_data),
    .i_valid(i_valid),
    .o_stop (o_stop),
    .o_data (o_data),
    .o_valid(o_valid),
    .i_stop (i_stop)
`ifdef LI_RS_STALL_COUNT_EN
    ,
    .o_stall_cycles(o_stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, then let the edge pass and settle before sampling.
  task automatic applyStimulus(input logic rst, input logic vld, input logic [WIDTH-1:0] dat, input logic stp);
    reset   = rst;
    i_valid = vld;
    i_data  = dat;
    i_stop  = stp;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOuts(input string tag, input logic vld, input logic [WIDTH-1:0] dat, input logic stp);
    checkOutput({tag, "_valid"}, 32'(o_valid), 32'(vld));
    checkOutput({tag, "_data"},  32'(o_data),  32'(dat));
    checkOutput({tag, "_stop"},  32'(o_stop),  32'(stp));
  endtask

  logic [WIDTH-1:0] exp_q[$];
  logic             have_tok;
  logic [WIDTH-1:0] tok_data;
  logic [WIDTH-1:0] seq;
  logic             up_take, dn_take;
  logic [WIDTH-1:0] dn_data;

  initial begin
    reset = 1'b1; i_valid = 1'b0; i_data = '0; i_stop = 1'b0;
    #1;

    // Reset holds outputs at zero even with a valid token offered
    applyStimulus(1'b1, 1'b1, 6'h15, 1'b0);
    checkOuts("reset0", 1'b0, 6'h00, 1'b0);
    applyStimulus(1'b1, 1'b1, 6'h15, 1'b0);
    checkOuts("reset1", 1'b0, 6'h00, 1'b0);
`ifdef LI_RS_STALL_COUNT_EN
    checkOutput("cnt_reset", 32'(o_stall_cycles), 32'd0);
`endif

    // Stream 1,2,3 with no back-pressure
    applyStimulus(1'b0, 1'b1, 6'd1, 1'b0);
    checkOuts("stream1", 1'b1, 6'd1, 1'b0);
    applyStimulus(1'b0, 1'b1, 6'd2, 1'b0);
    checkOuts("stream2", 1'b1, 6'd2, 1'b0);
    applyStimulus(1'b0, 1'b1, 6'd3, 1'b0);
    checkOuts("stream3", 1'b1, 6'd3, 1'b0);
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b0);
    checkOutput("stream_void", 32'(o_valid), 32'd0);

    // Stall: main=5, then 6 arrives under stop and parks in aux
    applyStimulus(1'b0, 1'b1, 6'd5, 1'b0);
    checkOuts("stall_load", 1'b1, 6'd5, 1'b0);
    applyStimulus(1'b0, 1'b1, 6'd6, 1'b1);
    checkOuts("stall_enter", 1'b1, 6'd5, 1'b1);
    applyStimulus(1'b0, 1'b1, 6'd7, 1'b1);
    checkOuts("stall_hold", 1'b1, 6'd5, 1'b1);
    applyStimulus(1'b0, 1'b1, 6'd7, 1'b0);
    checkOuts("stall_release", 1'b1, 6'd6, 1'b0);
    applyStimulus(1'b0, 1'b0, 6'd0, 1'b0);
    checkOuts("stall_after", 1'b0, 6'd0, 1'b0);

    // Void in main is overwritten despite stop
    applyStimulus(1'b0, 1'b1, 6'd9, 1'b1);
    checkOuts("void_overwrite", 1'b1, 6'd9, 1'b0);
    // Void input with valid main under stop: held, no stall
    applyStimulus(1'b0, 1'b0, 6'd12, 1'b1);
    checkOuts("void_drop", 1'b1, 6'd9, 1'b0);

    // Reset in the middle of a stall discards both tokens
    applyStimulus(1'b0, 1'b1, 6'd10, 1'b1);
    checkOuts("midrst_stall", 1'b1, 6'd9, 1'b1);
    applyStimulus(1'b1, 1'b1, 6'd11, 1'b1);
    checkOuts("midrst", 1'b0, 6'd0, 1'b0);

`ifdef LI_RS_STALL_COUNT_EN
    // Counter saturation at CNT_WIDTH=4
    applyStimulus(1'b0, 1'b1, 6'd20, 1'b0);
    applyStimulus(1'b0, 1'b1, 6'd21, 1'b1);
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1, 6'd22, 1'b1);
    checkOutput("cnt_sat", 32'(o_stall_cycles), 32'd15);
    applyStimulus(1'b1, 1'b0, 6'd0, 1'b0);
    checkOutput("cnt_clear", 32'(o_stall_cycles), 32'd0);
`endif

    // Random stop/valid against a reference queue
    applyStimulus(1'b1, 1'b0, 6'd0, 1'b0);
    have_tok = 1'b0;
    tok_data = '0;
    seq      = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (!have_tok && $urandom_range(0, 3) != 0) begin
        have_tok = 1'b1;
        tok_data = seq;
        seq      = seq + 1'b1;
      end
      reset   = 1'b0;
      i_valid = have_tok;
      i_data  = have_tok ? tok_data : WIDTH'($urandom);
      i_stop  = ($urandom_range(0, 2) == 0);
      #1;
      up_take = i_valid && !o_stop;
      dn_take = o_valid && !i_stop;
      dn_data = o_data;
      @(posedge clk);
      #1;
      if (dn_take) begin
        if (exp_q.size() == 0) begin
          checkOutput("rand_extra_token", 32'(dn_take), 32'd0);
        end else begin
          checkOutput("rand_data", 32'(dn_data), 32'(exp_q[0]));
          void'(exp_q.pop_front());
        end
      end
      if (up_take) begin
        exp_q.push_back(tok_data);
        have_tok = 1'b0;
      end
      if (exp_q.size() > 2) checkOutput("rand_depth", 32'(exp_q.size()), 32'd2);
    end

    // Drain whatever is left and confirm nothing was lost
    for (int d = 0; d < 4; d++) begin
      reset = 1'b0; i_valid = 1'b0; i_stop = 1'b0;
      #1;
      dn_take = o_valid;
      dn_data = o_data;
      @(posedge clk);
      #1;
      if (dn_take) begin
        if (exp_q.size() == 0) begin
          checkOutput("drain_extra_token", 32'(dn_take), 32'd0);
        end else begin
          checkOutput("drain_data", 32'(dn_data), 32'(exp_q[0]));
          void'(exp_q.pop_front());
        end
      end
    end
    checkOutput("drain_empty", 32'(exp_q.size()), 32'd0);
    checkOutput("drain_stop", 32'(o_stop), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
